// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction fetch controller
package imem_pkg;

  localparam int ADDR_W = 8;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hb400001f;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry registered-head FIFO with synchronous flush
module fetch_fifo #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic [1:0]   count;
  logic         pop_ok;
  logic         push_ok;

  // Guards make illegal requests harmless even if the caller misbehaves.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else               mem1 <= din;
        end
        2'b01: mem0 <= mem1;
        2'b11: begin
          if (count == 2'd1) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign dout  = mem0;
  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - sequential instruction fetch from ROM into a 2-deep buffer
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int          N         = 32,
  parameter logic [N-1:0] HALT_WORD = N'(HALT_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_q,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [N-1:0]      inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              halted
);

  fetch_state_t            state;
  logic [ADDR_W-1:0]       pc;
  logic                    flush;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_valid;
  logic [N+ADDR_W-1:0]     head;

  // Start only restarts from HALT; in IDLE the buffer is already empty.
  assign flush = (redirect && (state != IDLE)) || (start && (state == HALT));
  assign pop   = fifo_valid && inst_ready && !flush;
  assign push  = (state == RUN) && !flush && (!fifo_full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= start_addr;
          end
        end
        RUN: begin
          if (redirect) begin
            pc <= redirect_addr;
          end else if (push) begin
            if (imem_q == HALT_WORD) state <= HALT;
            else                     pc    <= pc + ADDR_W'(1);
          end
        end
        HALT: begin
          if (redirect) begin
            state <= RUN;
            pc    <= redirect_addr;
          end else if (start) begin
            state <= RUN;
            pc    <= start_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.W(N + ADDR_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     ({imem_q, pc}),
    .dout    (head),
    .valid   (fifo_valid),
    .full    (fifo_full)
  );

  assign imem_addr  = pc;
  assign inst_valid = fifo_valid;
  assign inst       = head[N+ADDR_W-1:ADDR_W];
  assign inst_pc    = head[ADDR_W-1:0];
  assign busy       = (state == RUN);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - vector-table bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        busy;
  logic        halted;

  logic [31:0] rom [0:255];
  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .start_addr    (start_addr),
    .imem_addr     (imem_addr),
    .imem_q        (imem_q),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .halted        (halted)
  );

  typedef struct {
    logic        st;
    logic [7:0]  sa;
    logic        rdy;
    logic        rd;
    logic [7:0]  ra;
    logic        v;
    logic [31:0] ins;
    logic [7:0]  ipc;
    logic [7:0]  ia;
    logic        bsy;
    logic        hlt;
  } vec_t;

  vec_t vecs [22];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic st, logic [7:0] sa, logic rdy, logic rd, logic [7:0] ra,
                              logic v, logic [31:0] ins, logic [7:0] ipc, logic [7:0] ia,
                              logic bsy, logic hlt);
    vec_t r;
    r.st = st; r.sa = sa; r.rdy = rdy; r.rd = rd; r.ra = ra;
    r.v = v; r.ins = ins; r.ipc = ipc; r.ia = ia; r.bsy = bsy; r.hlt = hlt;
    return r;
  endfunction

  task automatic check(string name, logic v, logic [31:0] ins, logic [7:0] ipc,
                       logic [7:0] ia, logic bsy, logic hlt, logic chk_data);
    logic bad;
    nvec++;
    bad = (inst_valid !== v) || (imem_addr !== ia) || (busy !== bsy) || (halted !== hlt) ||
          (chk_data && ((inst !== ins) || (inst_pc !== ipc)));
    if (bad) begin
      nmis++;
      $display("FAIL %s: got v=%b inst=%h pc=%0d addr=%0d busy=%b halt=%b, want v=%b inst=%h pc=%0d addr=%0d busy=%b halt=%b",
               name, inst_valid, inst, inst_pc, imem_addr, busy, halted,
               v, ins, ipc, ia, bsy, hlt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = 32'hd29fffe1; rom[1] = 32'hf8000001; rom[2] = 32'hd2955541; rom[3] = 32'hf8008001;
    rom[4] = 32'hf8400002; rom[5] = 32'h8b020043; rom[6] = 32'hf8010003; rom[7] = 32'hb400001f;

    // straight run 0..7 to HALT
    vecs[0]  = mk(1, 0,   1, 0, 0, 0, 32'h0,        0,   0,   1, 0);
    vecs[1]  = mk(0, 0,   1, 0, 0, 1, 32'hd29fffe1, 0,   1,   1, 0);
    vecs[2]  = mk(0, 0,   1, 0, 0, 1, 32'hf8000001, 1,   2,   1, 0);
    vecs[3]  = mk(0, 0,   1, 0, 0, 1, 32'hd2955541, 2,   3,   1, 0);
    vecs[4]  = mk(0, 0,   1, 0, 0, 1, 32'hf8008001, 3,   4,   1, 0);
    vecs[5]  = mk(0, 0,   1, 0, 0, 1, 32'hf8400002, 4,   5,   1, 0);
    vecs[6]  = mk(0, 0,   1, 0, 0, 1, 32'h8b020043, 5,   6,   1, 0);
    vecs[7]  = mk(0, 0,   1, 0, 0, 1, 32'hf8010003, 6,   7,   1, 0);
    vecs[8]  = mk(0, 0,   1, 0, 0, 1, 32'hb400001f, 7,   7,   0, 1);
    vecs[9]  = mk(0, 0,   1, 0, 0, 0, 32'h0,        0,   7,   0, 1);
    // restart from HALT at 254, wrap through 0
    vecs[10] = mk(1, 254, 1, 0, 0, 0, 32'h0,        0,   254, 1, 0);
    vecs[11] = mk(0, 0,   1, 0, 0, 1, 32'h0,        254, 255, 1, 0);
    vecs[12] = mk(0, 0,   1, 0, 0, 1, 32'h0,        255, 0,   1, 0);
    vecs[13] = mk(0, 0,   1, 0, 0, 1, 32'hd29fffe1, 0,   1,   1, 0);
    // redirect to 0 with consumer stalled, fill, then release
    vecs[14] = mk(0, 0,   0, 1, 0, 0, 32'h0,        0,   0,   1, 0);
    vecs[15] = mk(0, 0,   0, 0, 0, 1, 32'hd29fffe1, 0,   1,   1, 0);
    vecs[16] = mk(0, 0,   0, 0, 0, 1, 32'hd29fffe1, 0,   2,   1, 0);
    vecs[17] = mk(0, 0,   0, 0, 0, 1, 32'hd29fffe1, 0,   2,   1, 0);
    vecs[18] = mk(0, 0,   1, 0, 0, 1, 32'hf8000001, 1,   3,   1, 0);
    vecs[19] = mk(0, 0,   1, 0, 0, 1, 32'hd2955541, 2,   4,   1, 0);
    // redirect to 4 with two entries buffered
    vecs[20] = mk(0, 0,   1, 1, 4, 0, 32'h0,        0,   4,   1, 0);
    vecs[21] = mk(0, 0,   1, 0, 0, 1, 32'hf8400002, 4,   5,   1, 0);

    reset_n = 1'b0; start = 0; start_addr = 0; inst_ready = 0; redirect = 0; redirect_addr = 0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 0, 32'h0, 8'h0, 8'h0, 0, 0, 1);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].st; start_addr = vecs[i].sa; inst_ready = vecs[i].rdy;
      redirect = vecs[i].rd; redirect_addr = vecs[i].ra;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].v, vecs[i].ins, vecs[i].ipc, vecs[i].ia,
               vecs[i].bsy, vecs[i].hlt, vecs[i].v);
    end

    // fill to two entries, then async reset mid-RUN
    start = 0; redirect = 0; inst_ready = 0;
    @(posedge clk);
    #1 check("fill_before_reset", 1, 32'hf8400002, 8'd4, 8'd6, 1, 0, 1);
    reset_n = 1'b0;
    #1 check("async_reset", 0, 32'h0, 8'h0, 8'h0, 0, 0, 1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check("idle_after_reset", 0, 32'h0, 8'h0, 8'h0, 0, 0, 0);

    // run to HALT, then start and redirect together
    start = 1; start_addr = 0; inst_ready = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 20 && !halted; k++) begin
      @(posedge clk);
      #1;
    end
    check("reach_halt", inst_valid, 32'h0, 8'h0, 8'd7, 0, 1, 0);
    start = 1; start_addr = 0; redirect = 1; redirect_addr = 5;
    @(posedge clk);
    #1 check("halt_redirect_prio", 0, 32'h0, 8'h0, 8'd5, 1, 0, 0);
    start = 0; redirect = 0;
    @(posedge clk);
    #1 check("after_redirect5", 1, 32'h8b020043, 8'd5, 8'd6, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning instruction word width.
REQ-002 SHALL have parameter HALT_WORD, default 32'hb400001f, meaning the end-of-program word (CBZ XZR self-loop).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  pulse: begin fetching at start_addr.
REQ-006 SHALL have port start_addr  input  8  first word address.
REQ-007 SHALL have port imem_addr  output  8  word address to the instruction ROM.
REQ-008 SHALL have port imem_q  input  N  ROM data, combinational from imem_addr in the same cycle.
REQ-009 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  consumer accepts the head this cycle.
REQ-011 SHALL have port inst  output  N  head instruction word.
REQ-012 SHALL have port inst_pc  output  8  word address of the head instruction.
REQ-013 SHALL have port redirect  input  1  pulse: flush and refetch from redirect_addr.
REQ-014 SHALL have port redirect_addr  input  8  redirect target word address.
REQ-015 SHALL have port busy  output  1  high in state RUN.
REQ-016 SHALL have port halted  output  1  high in state HALT.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT.
REQ-018 SHALL drive imem_addr combinationally from the internal fetch pointer pc.
REQ-019 SHALL hold a 2-entry FIFO of {word, pc}; inst/inst_pc/inst_valid come from the registered head.
REQ-020 SHALL pop on inst_valid and inst_ready (handshake); inst and inst_pc SHALL hold stable while inst_valid and not inst_ready.
REQ-021 SHALL, in RUN with no redirect, push {imem_q, pc} and increment pc when count<2 or a pop occurs that cycle (push and pop with count=2 allowed).
REQ-022 SHALL wrap pc from 255 to 0 (8-bit modulo increment).
REQ-023 SHALL go IDLE->RUN on start, loading pc=start_addr; first push occurs the next cycle, inst_valid one cycle after that (start at t -> inst_valid at t+2).
REQ-024 SHALL, on pushing a word equal to HALT_WORD, go RUN->HALT; pc stays at the halt word address, no further pushes; FIFO continues to drain.
REQ-025 SHALL, on redirect in RUN or HALT, flush the FIFO (inst_valid=0 next cycle), load pc=redirect_addr, suppress that cycle's push and pop, and enter RUN.
REQ-026 SHALL ignore redirect in IDLE; ignore start in RUN.
REQ-027 SHALL accept start in HALT: flush the FIFO, load pc=start_addr, enter RUN.
REQ-028 SHALL give redirect priority over start when both are asserted in HALT.
REQ-029 SHALL never assert inst_valid with an empty FIFO nor push when full without a concurrent pop.

Reset
REQ-030 SHALL, on reset_n low, immediately set state=IDLE, pc=0 (imem_addr=0), FIFO empty, inst_valid=0, inst=0, inst_pc=0, busy=0, halted=0.
REQ-031 SHALL, on reset mid-RUN, discard buffered words; the first cycle after release is IDLE with no pushes.

Structure
REQ-032 SHALL take ADDR_W=8, the fetch_state_t enum (IDLE, RUN, HALT) and the HALT_WORD default from shared package imem_pkg.
REQ-033 SHALL instantiate one sub-module fetch_fifo (2-entry, synchronous flush input, width N+8).

Verification (ROM words 0..7 = d29fffe1, f8000001, d2955541, f8008001, f8400002, 8b020043, f8010003, b400001f; rest 0)
REQ-034 SHALL cover: start, start_addr=0, inst_ready=1 -> inst_valid from t+2, inst_pc 0..7 in consecutive cycles, inst 0xd29fffe1 .. 0xb400001f, halted=1 after the push at address 7, imem_addr holds 7.
REQ-035 SHALL cover: start at 0, inst_ready=0 -> FIFO fills with pc 0,1; imem_addr stalls at 2; head remains 0xd29fffe1; raise ready -> 0xf8000001 next, no loss or duplication.
REQ-036 SHALL cover: redirect to 4 with 2 entries buffered -> inst_valid=0 next cycle; next delivered inst=0xf8400002, inst_pc=4.
REQ-037 SHALL cover: start_addr=254 -> inst_pc 254, 255, 0 with inst 0x00000000, 0x00000000, 0xd29fffe1.
REQ-038 SHALL cover: reset_n low in RUN with 2 entries buffered -> inst_valid=0, imem_addr=0, busy=0 asynchronously, before the next clock edge.
REQ-039 SHALL cover: in HALT, start (addr 0) and redirect (addr 5) asserted together -> next delivered inst_pc=5, inst=0x8b020043.
